// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch control slice.
// Imported by stopwatch_ctrl and sw_btn_cond.
package stopwatch_pkg;

  localparam int   DIG_W    = 4;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sw_btn_cond.sv
// Button conditioner: 2-flop sync, tick-paced debounce, press pulse.
// Ports: clk, rst, tick_1ms, btn (raw) -> press (one-clk pulse on 0->1).
module sw_btn_cond
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1ms,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt;
  logic          flip;

  // sampled level differs from the accepted one
  assign flip = sync[1] ^ lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (tick_1ms) begin
        if (!flip) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_MS - 1)) begin
          cnt   <= '0;
          lvl   <= sync[1];
          press <= sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: buttons -> run/clr/dir, lap display, alarm.
// In: clk rst tick_1ms btn_* cnt_* ; out: cnt_run/clr/dir disp_* lap alarm state.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int ALARM_MS    = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic             btn_ss,
  input  logic             btn_lr,
  input  logic             btn_mode,
  input  logic [DIG_W-1:0] cnt_min,
  input  logic [DIG_W-1:0] cnt_smsd,
  input  logic [DIG_W-1:0] cnt_slsd,
  input  logic [DIG_W-1:0] cnt_ms,
  input  logic             cnt_limit,
  output logic             cnt_run,
  output logic             cnt_clr,
  output logic             cnt_dir,
  output logic [DIG_W-1:0] disp_min,
  output logic [DIG_W-1:0] disp_smsd,
  output logic [DIG_W-1:0] disp_slsd,
  output logic [DIG_W-1:0] disp_ms,
  output logic             lap_active,
  output logic             alarm,
  output logic [2:0]       state_o
);

  localparam int AW = $clog2(ALARM_MS + 1);

  logic p_ss, p_lr, p_mode;

  sw_btn_cond #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ss (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms),
    .btn(btn_ss), .press(p_ss)
  );
  sw_btn_cond #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_lr (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms),
    .btn(btn_lr), .press(p_lr)
  );
  sw_btn_cond #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_mode (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms),
    .btn(btn_mode), .press(p_mode)
  );

  state_t                 state, state_nxt;
  logic                   dir_nxt, clr_nxt, snap_ld;
  logic [4*DIG_W-1:0]     live, snap, disp;
  logic [AW-1:0]          tmr;

  assign live = {cnt_min, cnt_smsd, cnt_slsd, cnt_ms};

  // limit is checked before any press; ss shadows lr
  always_comb begin
    state_nxt = state;
    dir_nxt   = cnt_dir;
    clr_nxt   = 1'b0;
    snap_ld   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (p_ss) begin
          if (!cnt_limit) state_nxt = ST_RUN;
        end else if (p_lr) begin
          clr_nxt = 1'b1;
        end
        if (p_mode) dir_nxt = ~cnt_dir;
      end
      ST_RUN: begin
        if (cnt_limit) state_nxt = ST_DONE;
        else if (p_ss) state_nxt = ST_PAUSE;
        else if (p_lr) begin
          state_nxt = ST_LAP;
          snap_ld   = 1'b1;
        end
      end
      ST_LAP: begin
        if (cnt_limit) state_nxt = ST_DONE;
        else if (p_ss) state_nxt = ST_PAUSE;
        else if (p_lr) state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (p_ss) begin
          if (!cnt_limit) state_nxt = ST_RUN;
        end else if (p_lr) begin
          clr_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (p_ss || p_lr) begin
          clr_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt_dir <= DIR_UP;
      cnt_clr <= 1'b0;
      snap    <= '0;
      disp    <= '0;
      tmr     <= '0;
    end else begin
      state   <= state_nxt;
      cnt_dir <= dir_nxt;
      cnt_clr <= clr_nxt;
      if (snap_ld) snap <= live;
      disp <= lap_active ? snap : live;
      if (state != ST_DONE) begin
        tmr <= '0;
      end else if (tick_1ms && tmr != AW'(ALARM_MS)) begin
        tmr <= tmr + 1'b1;
      end
    end
  end

  assign cnt_run    = (state == ST_RUN) || (state == ST_LAP);
  assign lap_active = (state == ST_LAP);
  assign alarm      = (state == ST_DONE) && (cnt_dir == DIR_DOWN)
                   && (tmr != AW'(ALARM_MS));
  assign state_o    = state;

  assign {disp_min, disp_smsd, disp_slsd, disp_ms} = disp;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (DEBOUNCE_MS=3, ALARM_MS=5).
// tick_1ms pulses every 4th clk.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        btn_ss = 1'b0, btn_lr = 1'b0, btn_mode = 1'b0;
  logic [15:0] live = '0;
  logic        cnt_limit = 1'b0;
  logic        cnt_run, cnt_clr, cnt_dir;
  logic [3:0]  d_min, d_smsd, d_slsd, d_ms;
  logic        lap_active, alarm;
  logic [2:0]  state_o;
  logic [15:0] disp;

  int n_vec = 0;
  int n_err = 0;
  int clr_hi = 0;
  int tk = 0;

  assign disp = {d_min, d_smsd, d_slsd, d_ms};

  stopwatch_ctrl #(.DEBOUNCE_MS(3), .ALARM_MS(5)) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick),
    .btn_ss(btn_ss), .btn_lr(btn_lr), .btn_mode(btn_mode),
    .cnt_min(live[15:12]), .cnt_smsd(live[11:8]),
    .cnt_slsd(live[7:4]), .cnt_ms(live[3:0]),
    .cnt_limit(cnt_limit),
    .cnt_run(cnt_run), .cnt_clr(cnt_clr), .cnt_dir(cnt_dir),
    .disp_min(d_min), .disp_smsd(d_smsd),
    .disp_slsd(d_slsd), .disp_ms(d_ms),
    .lap_active(lap_active), .alarm(alarm), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick = (tk == 3);
      tk   = (tk + 1) % 4;
    end
  end

  // clk-wide samples of cnt_clr: one per pulse if width is exactly 1
  always @(negedge clk) if (cnt_clr) clr_hi <= clr_hi + 1;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!tick) @(negedge clk);
    end
  endtask

  task automatic press(input logic [2:0] b);
    {btn_mode, btn_lr, btn_ss} = b;
    wait_ticks(6);
    {btn_mode, btn_lr, btn_ss} = 3'b000;
    wait_ticks(6);
  endtask

  int c0;
  int n;
  bit found;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_run", 16'(cnt_run), 16'd0);
    chk("rst_clr", 16'(cnt_clr), 16'd0);
    chk("rst_dir", 16'(cnt_dir), 16'd1);
    chk("rst_lap", 16'(lap_active), 16'd0);
    chk("rst_alarm", 16'(alarm), 16'd0);
    chk("rst_disp", disp, 16'h0000);
    rst = 1'b0;
    wait_ticks(2);

    // bounce: toggle for 2 ticks, then held
    btn_ss = 1'b1; wait_ticks(1);
    btn_ss = 1'b0; wait_ticks(1);
    btn_ss = 1'b1; wait_ticks(5);
    btn_ss = 1'b0; wait_ticks(6);
    chk("bounce_state", 16'(state_o), 16'd1);
    chk("bounce_run", 16'(cnt_run), 16'd1);

    // lap
    live = 16'h1234;
    press(3'b010);
    chk("lap_state", 16'(state_o), 16'd3);
    chk("lap_active", 16'(lap_active), 16'd1);
    chk("lap_run", 16'(cnt_run), 16'd1);
    live = 16'h1250;
    repeat (3) @(negedge clk);
    chk("lap_frozen", disp, 16'h1234);
    press(3'b010);
    chk("unlap_state", 16'(state_o), 16'd1);
    chk("unlap_active", 16'(lap_active), 16'd0);
    chk("unlap_disp", disp, 16'h1250);
    live = 16'h1301;
    chk("disp_lat0", disp, 16'h1250);
    @(negedge clk);
    chk("disp_lat1", disp, 16'h1301);

    // pause / reset
    press(3'b001);
    chk("pause_state", 16'(state_o), 16'd2);
    chk("pause_run", 16'(cnt_run), 16'd0);
    c0 = clr_hi;
    press(3'b010);
    chk("pclr_state", 16'(state_o), 16'd0);
    chk("pclr_pulse", 16'(clr_hi - c0), 16'd1);

    // countdown
    press(3'b100);
    chk("mode_dir", 16'(cnt_dir), 16'd0);
    press(3'b001);
    chk("cd_run", 16'(state_o), 16'd1);
    @(negedge clk);
    cnt_limit = 1'b1;
    @(negedge clk);
    chk("cd_done", 16'(state_o), 16'd4);
    chk("cd_alarm_on", 16'(alarm), 16'd1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!alarm) break;
      if (tick) n++;
      @(negedge clk);
    end
    chk("alarm_ticks", 16'(n), 16'd5);
    chk("alarm_off", 16'(alarm), 16'd0);
    wait_ticks(3);
    chk("done_hold", 16'(state_o), 16'd4);
    c0 = clr_hi;
    press(3'b001);
    chk("done_exit", 16'(state_o), 16'd0);
    chk("done_clr", 16'(clr_hi - c0), 16'd1);
    chk("exit_alarm", 16'(alarm), 16'd0);
    press(3'b001);
    chk("idle_limit", 16'(state_o), 16'd0);
    cnt_limit = 1'b0;

    // ss + lr together
    press(3'b100);
    chk("mode_up", 16'(cnt_dir), 16'd1);
    press(3'b001);
    live = 16'h0777;
    c0 = clr_hi;
    press(3'b011);
    chk("both_state", 16'(state_o), 16'd2);
    chk("both_snap", dut.snap, 16'h1234);
    chk("both_noclr", 16'(clr_hi - c0), 16'd0);

    // limit and ss on the same clk
    press(3'b001);
    chk("resume", 16'(state_o), 16'd1);
    btn_ss = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.p_ss) begin
        found = 1'b1;
        break;
      end
    end
    chk("ss_seen", 16'(found), 16'd1);
    cnt_limit = 1'b1;
    @(negedge clk);
    chk("lim_prio", 16'(state_o), 16'd4);
    btn_ss = 1'b0;
    wait_ticks(6);
    chk("up_noalarm", 16'(alarm), 16'd0);
    cnt_limit = 1'b0;
    press(3'b010);
    chk("up_exit", 16'(state_o), 16'd0);

    // async reset in LAP
    press(3'b100);
    press(3'b001);
    press(3'b010);
    chk("pre_rst_lap", 16'(state_o), 16'd3);
    chk("pre_rst_dir", 16'(cnt_dir), 16'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 16'(state_o), 16'd0);
    chk("arst_dir", 16'(cnt_dir), 16'd1);
    chk("arst_run", 16'(cnt_run), 16'd0);
    chk("arst_lap", 16'(lap_active), 16'd0);
    chk("arst_disp", disp, 16'h0000);
    chk("arst_alarm", 16'(alarm), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
